// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the instruction memory loader.
//   byte_in    : program byte, source -> loader
//   byte_valid : byte_in carries a byte this cycle, source -> loader
//   byte_ready : loader accepts a byte this cycle, loader -> source
interface imem_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction memory with a byte-stream loader.
// A load packs a little-endian byte stream into N-bit words at entries 0..len-1,
// zero-fills entries len..DEPTH-1, then releases the processor.
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous active-low reset
//   start        : one-cycle pulse starting a load, honoured in IDLE or DONE
//   load_len     : words to load, sampled with start, clamped to DEPTH
//   bs           : byte-stream handshake (slave side)
//   cpu_hold     : holds the processor in reset while high (registered)
//   done         : program loaded and memory zero-filled (registered)
//   words_loaded : stream words written since the last start (registered)
//   addr / q     : combinational fetch port, q = mem[addr]
module imem_loader #(
    parameter int unsigned N     = 32,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEPTH = 2 ** AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW:0]       load_len,
    imem_loader_if.slave      bs,
    output logic              cpu_hold,
    output logic              done,
    output logic [AW:0]       words_loaded,
    input  logic [AW-1:0]     addr,
    output logic [N-1:0]      q
);

    // Bytes per word and width of the byte-within-word counter
    localparam int unsigned BPW = N / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic [AW:0]      wl_q, wl_d;
    logic [AW:0]      len_q, len_d;
    logic [N-1:0]     word_q, word_d;
    logic             byte_ready_q, byte_ready_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             done_q, done_d;

    logic [N-1:0]     mem [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [N-1:0]     mem_wdata;

    logic [AW:0]      len_clamp;
    logic             byte_fire;
    logic             word_fire;
    logic             last_word;
    logic [N-1:0]     word_asm;

    // Requested length limited to the memory depth
    assign len_clamp = (load_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : load_len;

    // A byte transfers only in LOAD, where byte_ready is high
    assign byte_fire = (state_q == S_LOAD) && bs.byte_valid;
    assign word_fire = byte_fire && (bcnt_q == BCW'(BPW - 1));
    assign last_word = ((wl_q + (AW+1)'(1)) == len_q);

    // Partial word with the incoming byte dropped into its little-endian slot
    always_comb begin
        word_asm = word_q;
        word_asm[32'(bcnt_q) * 8 +: 8] = bs.byte_in;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (len_clamp != '0) ? S_LOAD : S_CLEAR;
                end
            end
            S_LOAD: begin
                if (word_fire && last_word) begin
                    // A full-depth load has nothing left to clear
                    state_d = ((wptr_q + (AW+1)'(1)) < (AW+1)'(DEPTH)) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                if (wptr_q == (AW+1)'(DEPTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so they change only at edges
    always_comb begin
        byte_ready_d = (state_d == S_LOAD);
        cpu_hold_d   = (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    // Datapath: write pointer, byte packing, word counter and memory write request
    always_comb begin
        wptr_d    = wptr_q;
        bcnt_d    = bcnt_q;
        wl_d      = wl_q;
        len_d     = len_q;
        word_d    = word_q;
        mem_we    = 1'b0;
        mem_waddr = wptr_q[AW-1:0];
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d  = len_clamp;
                    wptr_d = '0;
                    bcnt_d = '0;
                    wl_d   = '0;
                    word_d = '0;
                end
            end
            S_LOAD: begin
                if (word_fire) begin
                    mem_we    = 1'b1;
                    mem_wdata = word_asm;
                    wptr_d    = wptr_q + (AW+1)'(1);
                    wl_d      = wl_q + (AW+1)'(1);
                    bcnt_d    = '0;
                    word_d    = '0;
                end else if (byte_fire) begin
                    word_d = word_asm;
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            S_CLEAR: begin
                mem_we = 1'b1;
                wptr_d = wptr_q + (AW+1)'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q       <= '0;
            bcnt_q       <= '0;
            wl_q         <= '0;
            len_q        <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            bcnt_q       <= bcnt_d;
            wl_q         <= wl_d;
            len_q        <= len_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational fetch port; a same-cycle write shows up only after the edge
    assign q = mem[addr];

    assign bs.byte_ready = byte_ready_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign words_loaded  = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads
// compared against an array model of the expected memory image.
module tb_imem_loader;
    localparam int N     = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          cpu_hold;
    logic          done;
    logic [AW:0]   words_loaded;
    logic [AW-1:0] addr = '0;
    logic [N-1:0]  q;

    imem_loader_if bs();

    imem_loader #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_len     (load_len),
        .bs           (bs),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .words_loaded (words_loaded),
        .addr         (addr),
        .q            (q)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] prog    [DEPTH];
    logic [N-1:0] exp_mem [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int ll);
        load_len = (AW+1)'(ll);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; ok=0 if it is never accepted
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bs.byte_valid = 1'b0;
        repeat (gap) tick();
        bs.byte_in    = b;
        bs.byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bs.byte_ready === 1'b1) ok = 1'b1;
            tick();
        end
        bs.byte_valid = 1'b0;
    endtask

    // Stream prog[0..nwords-1]; gapmode<0 picks a random gap per byte
    task automatic load_words(input int nwords, input int gapmode, output bit ok);
        bit okb;
        logic [N-1:0] wv;
        ok = 1'b1;
        for (int w = 0; w < nwords; w++) begin
            wv = prog[w];
            for (int k = 0; k < N / 8; k++) begin
                send_byte(wv[8*k +: 8], (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode, okb);
                if (!okb) ok = 1'b0;
            end
        end
    endtask

    // Cycles until done rises, bounded
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    // Reference image after a complete load of 'eff' words
    function automatic void model_full_load(input int eff);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = (i < eff) ? prog[i] : '0;
    endfunction

    function automatic int clamp_len(input int ll);
        return (ll > DEPTH) ? DEPTH : ll;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bs.byte_valid = 1'b1;
        bs.byte_in = 8'h5a;
        repeat (2) tick();
        checks++; if (bs.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bs.byte_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", cpu_hold); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (words_loaded !== '0) begin errors++; $display("FAIL reset_wl got=%0d exp=0", words_loaded); end
        reset = 1'b1;
        repeat (4) tick();
        checks++; if (bs.byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== '0) begin
            errors++; $display("FAIL idle_stable ready=%b hold=%b done=%b wl=%0d exp 0/1/0/0", bs.byte_ready, cpu_hold, done, words_loaded);
        end
        bs.byte_valid = 1'b0;
    endtask

    task automatic test_single_word();
        bit ok; int cyc;
        prog[0] = 32'h8b00001e;
        pulse_start(1);
        checks++; if (bs.byte_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", bs.byte_ready); end
        load_words(1, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept got=%b exp=1", ok); end
        checks++; if (words_loaded !== 7'd1) begin errors++; $display("FAIL single_wl got=%0d exp=1", words_loaded); end
        checks++; if (bs.byte_ready !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL single_clearing ready=%b done=%b hold=%b exp 0/0/1", bs.byte_ready, done, cpu_hold);
        end
        wait_done(cyc);
        checks++; if (cyc != 63) begin errors++; $display("FAIL single_clear_cycles got=%0d exp=63", cyc); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL single_hold got=%b exp=0", cpu_hold); end
        model_full_load(1);
        addr = 6'd0; #1;
        checks++; if (q !== 32'h8b00001e) begin errors++; $display("FAIL single_q0 got=%h exp=8b00001e", q); end
        addr = 6'd5; #1;
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL single_q5 got=%h exp=0", q); end
        tick();
    endtask

    task automatic test_throttled();
        bit ok; int cyc;
        prog[0] = 32'h8b00001e; prog[1] = 32'h91003c0a; prog[2] = 32'haa14018b;
        pulse_start(3);
        load_words(3, 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL thr_accept got=%b exp=1", ok); end
        wait_done(cyc);
        checks++; if (cyc != 61) begin errors++; $display("FAIL thr_done_latency got=%0d exp=61", cyc); end
        checks++; if (words_loaded !== 7'd3) begin errors++; $display("FAIL thr_wl got=%0d exp=3", words_loaded); end
        model_full_load(3);
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a); tick();
            checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL thr_mem[%0d] got=%h exp=%h", a, q, exp_mem[a]); end
        end
    endtask

    task automatic test_len_zero();
        int cyc;
        pulse_start(0);
        bs.byte_valid = 1'b1;
        bs.byte_in = 8'hff;
        checks++; if (bs.byte_ready !== 1'b0) begin errors++; $display("FAIL len0_ready got=%b exp=0", bs.byte_ready); end
        wait_done(cyc);
        bs.byte_valid = 1'b0;
        checks++; if (cyc != 64) begin errors++; $display("FAIL len0_clear_cycles got=%0d exp=64", cyc); end
        checks++; if (words_loaded !== '0) begin errors++; $display("FAIL len0_wl got=%0d exp=0", words_loaded); end
        model_full_load(0);
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a); tick();
            checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL len0_mem[%0d] got=%h exp=%h", a, q, exp_mem[a]); end
        end
    endtask

    task automatic test_clamp();
        bit ok; int cyc; int saw_ready;
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        pulse_start(100);
        load_words(DEPTH, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_accept got=%b exp=1", ok); end
        wait_done(cyc);
        checks++; if (cyc != 0) begin errors++; $display("FAIL clamp_done_latency got=%0d exp=0", cyc); end
        checks++; if (words_loaded !== 7'd64) begin errors++; $display("FAIL clamp_wl got=%0d exp=64", words_loaded); end
        // 257th byte must never be accepted
        bs.byte_valid = 1'b1;
        bs.byte_in = 8'h77;
        saw_ready = 0;
        repeat (4) begin
            if (bs.byte_ready !== 1'b0) saw_ready++;
            tick();
        end
        bs.byte_valid = 1'b0;
        checks++; if (saw_ready != 0) begin errors++; $display("FAIL clamp_257th ready_cycles=%0d exp=0", saw_ready); end
        model_full_load(DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a); tick();
            checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL clamp_mem[%0d] got=%h exp=%h", a, q, exp_mem[a]); end
        end
    endtask

    task automatic test_ignored_start_reload();
        bit ok; int cyc;
        logic [N-1:0] w0, w1;
        prog[0] = $urandom; prog[1] = $urandom;
        w0 = prog[0]; w1 = prog[1];
        pulse_start(2);
        checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reload_hold hold=%b done=%b exp 1/0", cpu_hold, done);
        end
        for (int k = 0; k < 3; k++) begin
            send_byte(w0[8*k +: 8], 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL reload_byte%0d accept got=%b exp=1", k, ok); end
        end
        pulse_start(5);
        checks++; if (words_loaded !== '0 || bs.byte_ready !== 1'b1) begin
            errors++; $display("FAIL ignored_start wl=%0d ready=%b exp 0/1", words_loaded, bs.byte_ready);
        end
        send_byte(w0[31:24], 0, ok);
        for (int k = 0; k < 4; k++) send_byte(w1[8*k +: 8], 0, ok);
        checks++; if (!ok || words_loaded !== 7'd2) begin
            errors++; $display("FAIL reload_wl got=%0d ok=%b exp=2", words_loaded, ok);
        end
        wait_done(cyc);
        checks++; if (cyc != 62) begin errors++; $display("FAIL reload_clear_cycles got=%0d exp=62", cyc); end
        model_full_load(2);
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a); tick();
            checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL reload_mem[%0d] got=%h exp=%h", a, q, exp_mem[a]); end
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        logic [N-1:0] w0, w1;
        for (int i = 0; i < 4; i++) prog[i] = $urandom;
        prog[1] = ~exp_mem[1];
        w0 = prog[0]; w1 = prog[1];
        pulse_start(4);
        for (int k = 0; k < 4; k++) send_byte(w0[8*k +: 8], 0, ok);
        for (int k = 0; k < 2; k++) send_byte(w1[8*k +: 8], 0, ok);
        reset = 1'b0;
        tick();
        checks++; if (bs.byte_ready !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || words_loaded !== '0) begin
            errors++; $display("FAIL midreset ready=%b hold=%b done=%b wl=%0d exp 0/1/0/0", bs.byte_ready, cpu_hold, done, words_loaded);
        end
        reset = 1'b1;
        repeat (3) tick();
        exp_mem[0] = w0;
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a); tick();
            checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL midreset_mem[%0d] got=%h exp=%h", a, q, exp_mem[a]); end
        end
        checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++; $display("FAIL midreset_idle done=%b hold=%b exp 0/1", done, cpu_hold);
        end
    endtask

    task automatic test_random();
        bit ok; int cyc; int ll; int eff;
        for (int it = 0; it < 4; it++) begin
            ll  = $urandom_range(0, 80);
            eff = clamp_len(ll);
            for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
            pulse_start(ll);
            load_words(eff, -1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_accept len=%0d got=%b exp=1", it, ll, ok); end
            wait_done(cyc);
            checks++; if (cyc != DEPTH - eff) begin errors++; $display("FAIL rand%0d_latency len=%0d got=%0d exp=%0d", it, ll, cyc, DEPTH - eff); end
            checks++; if (words_loaded !== (AW+1)'(eff)) begin errors++; $display("FAIL rand%0d_wl got=%0d exp=%0d", it, words_loaded, eff); end
            model_full_load(eff);
            for (int a = 0; a < DEPTH; a++) begin
                addr = AW'(a); tick();
                checks++; if (q !== exp_mem[a]) begin errors++; $display("FAIL rand%0d_mem[%0d] got=%h exp=%h", it, a, q, exp_mem[a]); end
            end
        end
    endtask

    initial begin
        bs.byte_in    = 8'h00;
        bs.byte_valid = 1'b0;
        test_reset();
        test_single_word();
        test_throttled();
        test_len_zero();
        test_clamp();
        test_ignored_start_reload();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writable instruction memory with a byte-stream loader. Replaces the fixed instruction ROM when programs are loaded at run time. Accepts a program as a stream of bytes over a valid/ready handshake and packs them into N-bit instruction words. Zero-fills all unused entries, then releases the processor. The fetch side keeps the same combinational addr -> q read port as the instruction ROM.

Parameters:
N, 32, instruction word width in bits; must be a multiple of 8
AW, 6, address width
DEPTH, 64, number of words; equals 2**AW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE
load_len  in  AW+1  number of words to load; sampled with start; values above DEPTH clamp to DEPTH
byte_in  in  8  program byte
byte_valid  in  1  byte_in is valid this cycle
byte_ready  out  1  loader accepts a byte this cycle
cpu_hold  out  1  holds the processor in reset while high
done  out  1  program loaded and memory zero-filled
words_loaded  out  AW+1  count of stream words written so far
addr  in  AW  fetch address
q  out  N  instruction word at addr; combinational read

Behaviour:
- States: IDLE, LOAD, CLEAR, DONE. A single write pointer wptr (AW+1 bits) is shared by LOAD and CLEAR.
- While reset=0 at a clock edge:
  - state <= IDLE; wptr, byte counter, words_loaded <= 0.
  - byte_ready=0, cpu_hold=1, done=0.
  - Memory contents are not cleared by reset.
- IDLE:
  - byte_ready=0, cpu_hold=1.
  - On start: latch len = min(load_len, DEPTH); wptr <= 0.
  - Next state is LOAD if len>0, otherwise CLEAR.
- LOAD:
  - byte_ready=1 whenever in LOAD. A byte transfers when byte_valid && byte_ready.
  - Bytes are packed little-endian: the 1st byte goes to [7:0], the 4th byte to [31:24].
  - On the edge of the N/8-th byte: mem[wptr] <= assembled word; wptr++, words_loaded++; byte counter <= 0.
  - Bytes offered while byte_valid=0 are ignored. Gaps between bytes are unlimited.
  - When the written word is number len: next state is CLEAR if wptr+1 < DEPTH, else DONE. byte_ready is 0 from the next cycle.
- CLEAR:
  - byte_ready=0. Each cycle: mem[wptr] <= 0; wptr++.
  - After writing entry DEPTH-1, go to DONE.
  - CLEAR takes DEPTH-len cycles.
- DONE:
  - cpu_hold=0, done=1, byte_ready=0.
  - start restarts the load: same action as in IDLE. cpu_hold=1 and done=0 from the next cycle.
- start asserted in LOAD or CLEAR is ignored.
- Read port:
  - q = mem[addr] combinationally, in every state.
  - A write and a read of the same entry in the same cycle: q shows the old value until after the edge.
- Reset mid-LOAD or mid-CLEAR:
  - Return to IDLE and discard any partial word.
  - Already-written entries are retained; done=0 until a full load completes.
- cpu_hold and done are registered outputs derived from the state. They never toggle within a cycle.

Test Plan:
- Reset then idle: after reset held low 2 cycles -> byte_ready=0, cpu_hold=1, done=0, words_loaded=0. Stays so with byte_valid=1.
- Single word: start with load_len=1; bytes 1e,00,00,8b -> mem[0]=0x8b00001e, words_loaded=1. Then 63 CLEAR cycles. Then done=1, cpu_hold=0, addr=0 -> q=0x8b00001e, addr=5 -> q=0.
- Throttled 3-word load: load_len=3 (0x8b00001e, 0x91003c0a, 0xaa14018b), byte_valid toggling every other cycle -> q at addr 0..2 matches, addr 3..63 = 0. done asserts exactly 61 cycles after the last byte edge.
- Boundaries:
  - load_len=0 -> no byte accepted, 64 CLEAR cycles, done=1.
  - load_len=100 -> clamped; 256 bytes accepted, no CLEAR, done=1 the cycle after the last byte; the 257th byte is not accepted (byte_ready=0).
- Ignored start and reload: start pulsed mid-LOAD -> ignored, counters unaffected. start in DONE with load_len=2 -> cpu_hold=1 the next cycle, new words at 0..1, remainder re-zeroed.
- Reset mid-op: reset low after 6 bytes of a 4-word load -> IDLE, words_loaded=0, cpu_hold=1. mem[0] keeps its word. The partial 2-byte word is never written.
